proc_multiciclo_mem: RTL
========================

// Module: proc_multiciclo_mem
// PURPOSE
//  Parametrised multicycle processor: NREGS x DATA_W register file, R[NREGS-1] = PC, fetches its own
//  instructions from a synchronous RAM (1-cycle read latency) via ADDR/DOUT/W. Adds ld, st, mvnz, slt
//  and a Z flag. Top-level board wrapper drives ADDR[4:0] into ramlpm and shows Buswires/Ciclo on LEDR/HEX.
// PARAMETERS
//  DATA_W  16  datapath, bus, register, DIN/DOUT width
//  NREGS   8   register count, power of 2, >= 2; SEL_W = $clog2(NREGS); last register is PC
//  ADDR_W  16  address output width (ADDR = ADDR_reg[ADDR_W-1:0]); ADDR_W <= DATA_W
// PORTS
//  Clock     in   1        single clock, all state updates on rising edge
//  Resetn    in   1        synchronous, active-high reset (name kept from existing processor)
//  Run       in   1        1 = fetch/execute; sampled only in step T0
//  DIN       in   DATA_W   RAM read data
//  ADDR      out  ADDR_W   RAM address (registered)
//  DOUT      out  DATA_W   RAM write data (registered)
//  W         out  1        RAM write enable (registered)
//  Done      out  1        high exactly one cycle: final step of each instruction
//  Buswires  out  DATA_W   internal bus value (debug)
//  Ciclo     out  3        current step T0..T5 (debug)
// BEHAVIOUR
//  Instruction in DIN[3+2*SEL_W-1:0]: op=[top 3], X=[2*SEL_W-1:SEL_W], Y=[SEL_W-1:0]; DATA_W >= 3+2*SEL_W.
//  Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 ld, 101 st, 110 mvnz, 111 slt.
//  Reset: all regs/PC/A/G/IR/ADDR/DOUT=0, W=0, Z=0, Ciclo=0; Done=0 (Done decoded from state, 0 in T0).
//   Reset wins over every other event, incl. mid-instruction and during a st write cycle.
//  Steps (unlisted step = no bus driver, nothing written; bus idles at 0):
//   T0: if Run=0 stay T0, no effect. Else bus=PC, ADDR<=bus, PC<=PC+1 -> T1
//   T1: RAM latency wait -> T2
//   T2: IR<=DIN -> T3
//   T3: mv: Rx<=Ry, Done. mvnz: if Z=0 Rx<=Ry; Done either way. mvi: bus=PC, ADDR<=bus, PC<=PC+1.
//       add/sub/slt: A<=Rx. ld/st: ADDR<=Ry.
//   T4: add/sub/slt: G<=A op Ry, Z<=(result==0). st: DOUT<=Rx, W<=1 (W high during T5). mvi/ld: wait.
//   T5: mvi/ld: Rx<=DIN, Done. add/sub/slt: Rx<=G, Done. st: RAM writes at end of T5, Done; W<=0.
//  After Done step -> T0 on next edge (Ciclo wraps to 0). Latency: mv/mvnz 4 cycles, others 6.
//  Arithmetic: add/sub modulo 2^DATA_W, no carry out; slt = signed(A) < signed(Ry) ? 1 : 0.
//  Z only changes on add/sub/slt T4; mv/mvi/ld do not affect Z.
//  PC as destination (X=NREGS-1) = jump; bus write to PC never coincides with increment in same cycle.
//  PC wraps NREGS... PC wraps at 2^DATA_W; ADDR truncates to ADDR_W bits.
//  Run dropped mid-instruction: instruction completes; halt takes effect at next T0.
// STRUCTURE
//  Shared include proc_defs.vh: opcode constants, step encodings T0..T5, ALU op select.
//  Sub-modules: regn (parametrised by DATA_W), proc_alu (add/sub/slt + zero flag output);
//  bus mux, step counter and control decode live in this module.
// TESTING
//  1 Reset mid-add (assert Resetn in T4) -> next cycle Ciclo=0, W=0, all regs 0, Done=0.
//  2 Run=0 for 10 cycles after reset -> Ciclo stays 0, ADDR=0, PC=0, no RAM access.
//  3 RAM: mvi R0,#5; mvi R1,#3; sub R0,R1 -> R0=2, Z=0, each Done one cycle, sub done in 6 cycles.
//  4 sub R2,R2 then mvnz R3,R0 -> Z=1, R3 unchanged; after add making nonzero, mvnz copies R0 to R3.
//  5 st R0,[R1] (R0=0xBEEF,R1=0x10) then ld R4,[R1] -> W=1 only in T5 with ADDR=0x10, DOUT=0xBEEF; R4=0xBEEF.
//  6 slt with R0=0xFFFF, R1=1 -> result 1 (signed); mv R7,R5 (R5=0x08) -> next fetch ADDR=0x08.
//  Also: DATA_W=8/NREGS=4 instance runs test 3 with 7-bit encoding.

Source files
------------

// File: rtl/proc_multiciclo_mem_pkg.sv
// Shared definitions for the multicycle processor: opcodes, step encodings and
// ALU operation select.
package proc_multiciclo_mem_pkg;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_LD   = 3'b100,
        OP_ST   = 3'b101,
        OP_MVNZ = 3'b110,
        OP_SLT  = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } step_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_SLT = 2'd2
    } alu_op_e;

    function automatic alu_op_e alu_sel(opcode_e op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/proc_multiciclo_mem_if.sv
// RAM-side bus of the processor: registered address, write data and write
// enable out, synchronous read data in.
interface proc_multiciclo_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DOUT;
    logic [DATA_W-1:0] DIN;
    logic              W;

    modport master (output ADDR, output DOUT, output W, input DIN);
    modport slave  (input ADDR, input DOUT, input W, output DIN);
endinterface

// File: rtl/proc_multiciclo_mem_alu.sv
// Combinational ALU: add, subtract and signed set-less-than, plus a zero flag
// on the result.
module proc_multiciclo_mem_alu
    import proc_multiciclo_mem_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  alu_op_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    always_comb begin
        result_o = a_i + b_i;
        case (op_i)
            ALU_SUB: result_o = a_i - b_i;
            ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: result_o = a_i + b_i;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/proc_multiciclo_mem.sv
// Multicycle processor fetching its own instructions from a synchronous RAM.
// The last register of the file is the PC; Done marks each instruction's final step.
module proc_multiciclo_mem
    import proc_multiciclo_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 16
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     Run,
    proc_multiciclo_mem_if.master    mem,
    output logic                     Done,
    output logic [DATA_W-1:0]        Buswires,
    output logic [2:0]               Ciclo
);

    localparam int SEL_W = $clog2(NREGS);
    localparam int IR_W  = 3 + 2 * SEL_W;
    localparam int PC    = NREGS - 1;
    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] g_q;
    logic [IR_W-1:0]   ir_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dout_q;
    logic              w_q;
    logic              z_q;
    step_e             step_q;

    opcode_e           op;
    logic [SEL_W-1:0]  rx;
    logic [SEL_W-1:0]  ry;
    logic [DATA_W-1:0] bus;
    logic              done;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    assign op = opcode_e'(ir_q[IR_W-1 -: 3]);
    assign rx = ir_q[2*SEL_W-1:SEL_W];
    assign ry = ir_q[SEL_W-1:0];

    // Bus driver and Done are a pure decode of the current step and opcode.
    always_comb begin
        // NOTE: defaults first so no path leaves bus/done unassigned and infers a latch.
        bus  = '0;
        done = 1'b0;
        case (step_q)
            T0: if (Run) bus = regs_q[PC];
            T3: begin
                case (op)
                    OP_MV, OP_MVNZ: begin
                        bus  = regs_q[ry];
                        done = 1'b1;
                    end
                    OP_MVI:                 bus = regs_q[PC];
                    OP_ADD, OP_SUB, OP_SLT: bus = regs_q[rx];
                    OP_LD, OP_ST:           bus = regs_q[ry];
                    default:                bus = '0;
                endcase
            end
            T4: begin
                case (op)
                    OP_ADD, OP_SUB, OP_SLT: bus = regs_q[ry];
                    OP_ST:                  bus = regs_q[rx];
                    default:                bus = '0;
                endcase
            end
            T5: begin
                done = 1'b1;
                case (op)
                    OP_MVI, OP_LD:          bus = mem.DIN;
                    OP_ADD, OP_SUB, OP_SLT: bus = g_q;
                    default:                bus = '0;
                endcase
            end
            default: bus = '0;
        endcase
    end

    proc_multiciclo_mem_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i     (alu_sel(op)),
        .a_i      (a_q),
        .b_i      (bus),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            // NOTE: the register file is cleared explicitly because the PC lives in it.
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            a_q    <= '0;
            g_q    <= '0;
            ir_q   <= '0;
            addr_q <= '0;
            dout_q <= '0;
            w_q    <= 1'b0;
            z_q    <= 1'b0;
            step_q <= T0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the bus.
            case (step_q)
                T0: if (Run) begin
                    addr_q     <= bus[ADDR_W-1:0];
                    regs_q[PC] <= regs_q[PC] + ONE;
                    step_q     <= T1;
                end
                T1: step_q <= T2;
                T2: begin
                    ir_q   <= mem.DIN[IR_W-1:0];
                    step_q <= T3;
                end
                T3: begin
                    step_q <= T4;
                    case (op)
                        OP_MV: begin
                            regs_q[rx] <= bus;
                            step_q     <= T0;
                        end
                        OP_MVNZ: begin
                            if (!z_q) regs_q[rx] <= bus;
                            step_q <= T0;
                        end
                        OP_MVI: begin
                            addr_q     <= bus[ADDR_W-1:0];
                            regs_q[PC] <= regs_q[PC] + ONE;
                        end
                        OP_ADD, OP_SUB, OP_SLT: a_q <= bus;
                        default:                addr_q <= bus[ADDR_W-1:0];
                    endcase
                end
                T4: begin
                    step_q <= T5;
                    case (op)
                        OP_ADD, OP_SUB, OP_SLT: begin
                            g_q <= alu_result;
                            z_q <= alu_zero;
                        end
                        OP_ST: begin
                            dout_q <= bus;
                            w_q    <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    step_q <= T0;
                    if (op == OP_ST) w_q <= 1'b0;
                    else regs_q[rx] <= bus;
                end
                default: step_q <= T0;
            endcase
        end
    end

    assign mem.ADDR = addr_q;
    assign mem.DOUT = dout_q;
    assign mem.W    = w_q;
    assign Done     = done;
    assign Buswires = bus;
    assign Ciclo    = step_q;

endmodule
